// File: rtl/arith_mod_reduct_solinas3_pkg.sv
// Solinas3 reduction: elaboration-time helpers.
// Recovers P0/P1 from MOD and sizes the fold pipeline.
package arith_mod_reduct_solinas3_pkg;

  localparam int MAX_W = 256;

  typedef struct packed {
    logic [15:0] p0;
    logic [15:0] p1;
  } int_pow_t;

  // 2^W - MOD + 1 = 2^P0 + 2^P1, so the top and
  // bottom set bits of that value are P0 and P1.
  function automatic int_pow_t get_int_pow(
    input logic [MAX_W-1:0] mod,
    input int               mod_w
  );
    logic [MAX_W-1:0] d;
    int_pow_t         r;
    d = (MAX_W'(1) << mod_w) - mod + MAX_W'(1);
    r = '0;
    for (int i = 0; i < MAX_W; i++)
      if (d[i]) r.p0 = 16'(i);
    for (int i = MAX_W - 1; i >= 0; i--)
      if (d[i]) r.p1 = 16'(i);
    return r;
  endfunction

  // Width of one fold's result for a w-bit operand.
  function automatic int fold_out_w(
    input int w,
    input int mod_w,
    input int p0
  );
    int hw;
    hw = w - mod_w;
    return ((mod_w > hw + p0) ? mod_w : hw + p0) + 1;
  endfunction

  // Width entering fold number `stage` (0 = raw input).
  function automatic int get_fold_w(
    input int stage,
    input int in_w,
    input int mod_w,
    input int p0
  );
    int w;
    w = in_w;
    for (int s = 0; s < stage; s++)
      w = fold_out_w(w, mod_w, p0);
    return w;
  endfunction

  function automatic int get_fold_nb(
    input int in_w,
    input int mod_w,
    input int p0
  );
    int w;
    int n;
    w = in_w;
    n = 0;
    while (w > mod_w + 1 && n < 64) begin
      w = fold_out_w(w, mod_w, p0);
      n++;
    end
    return n;
  endfunction

  function automatic int get_latency(
    input int in_pipe,
    input int fold_nb
  );
    return in_pipe + fold_nb + 1;
  endfunction

endpackage

// File: rtl/arith_mod_reduct_solinas3_fold.sv
// One registered Solinas3 fold: x' = lo + hi*(2^P0+2^P1-1).
// Ports: x_i/avail_i/side_i in, x_o/avail_o/side_o one clock later.
module arith_mod_reduct_solinas3_fold
  import arith_mod_reduct_solinas3_pkg::*;
#(
  parameter int         IN_W     = 128,
  parameter int         MOD_W    = 64,
  parameter int         P0       = 42,
  parameter int         P1       = 21,
  parameter int         SIDE_W   = 1,
  parameter logic [1:0] RST_SIDE = 2'b00,
  localparam int        OUT_W    = fold_out_w(IN_W, MOD_W, P0)
) (
  input  logic              clk,
  input  logic              s_rst,
  input  logic [IN_W-1:0]   x_i,
  input  logic              avail_i,
  input  logic [SIDE_W-1:0] side_i,
  output logic [OUT_W-1:0]  x_o,
  output logic              avail_o,
  output logic [SIDE_W-1:0] side_o
);

  localparam int HI_W = IN_W - MOD_W;

  logic [MOD_W-1:0] lo;
  logic [HI_W-1:0]  hi;
  logic [OUT_W-1:0] hi_e;
  logic [OUT_W-1:0] x_d;
  logic [OUT_W-1:0] x_q;

  assign lo   = x_i[MOD_W-1:0];
  assign hi   = x_i[IN_W-1:MOD_W];
  assign hi_e = OUT_W'(hi);

  // 2^MOD_W == 2^P0 + 2^P1 - 1; P0 >= 1 keeps it >= 0.
  assign x_d = OUT_W'(lo)
             + (hi_e << P0)
             + (hi_e << P1)
             - hi_e;

  always_ff @(posedge clk) x_q <= x_d;

  assign x_o = x_q;

  common_lib_delay_side #(
    .SIDE_W   (SIDE_W),
    .RST_SIDE (RST_SIDE)
  ) u_dly (
    .clk       (clk),
    .s_rst     (s_rst),
    .in_avail  (avail_i),
    .in_side   (side_i),
    .out_avail (avail_o),
    .out_side  (side_o)
  );

endmodule

// File: rtl/common_lib_delay_side.sv
// One register stage for a valid flag plus side data.
// Ports: clk, s_rst, in_avail/in_side -> out_avail/out_side.
module common_lib_delay_side #(
  parameter int         SIDE_W   = 1,
  parameter logic [1:0] RST_SIDE = 2'b00
) (
  input  logic              clk,
  input  logic              s_rst,
  input  logic              in_avail,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_avail,
  output logic [SIDE_W-1:0] out_side
);

  logic              avail_q;
  logic [SIDE_W-1:0] side_q;

  always_ff @(posedge clk) begin
    if (s_rst) avail_q <= 1'b0;
    else       avail_q <= in_avail;
  end

  // RST_SIDE[0] wins over RST_SIDE[1]; with
  // neither set the side data is never reset.
  always_ff @(posedge clk) begin
    if (s_rst && RST_SIDE[0])
      side_q <= '0;
    else if (s_rst && RST_SIDE[1])
      side_q <= '1;
    else
      side_q <= in_side;
  end

  assign out_avail = avail_q;
  assign out_side  = side_q;

endmodule

// File: rtl/arith_mod_reduct_solinas3.sv
// Pipelined reduction of a wide operand mod a Solinas3 prime.
// Ports: clk, s_rst, a/in_avail/in_side in; z/out_avail/out_side out.
module arith_mod_reduct_solinas3
  import arith_mod_reduct_solinas3_pkg::*;
#(
  parameter int               MOD_W    = 64,
  parameter logic [MOD_W-1:0] MOD      = 64'hFFFF_FBFF_FFE0_0001,
  parameter int               IN_W     = 2 * MOD_W,
  parameter int               IN_PIPE  = 1,
  parameter int               SIDE_W   = 0,
  parameter logic [1:0]       RST_SIDE = 2'b00,
  localparam int              SW       = (SIDE_W > 0) ? SIDE_W : 1
) (
  input  logic             clk,
  input  logic             s_rst,
  input  logic [IN_W-1:0]  a,
  input  logic             in_avail,
  input  logic [SW-1:0]    in_side,
  output logic [MOD_W-1:0] z,
  output logic             out_avail,
  output logic [SW-1:0]    out_side
);

  localparam int_pow_t POW = get_int_pow(MAX_W'(MOD), MOD_W);
  localparam int P0 = int'(POW.p0);
  localparam int P1 = int'(POW.p1);
  localparam int FOLD_NB = get_fold_nb(IN_W, MOD_W, P0);
  localparam int LATENCY = get_latency(IN_PIPE, FOLD_NB);

  localparam logic [MAX_W-1:0] MOD_CHK =
    (MAX_W'(1) << MOD_W) - (MAX_W'(1) << P0)
    - (MAX_W'(1) << P1) + MAX_W'(1);

  if (MOD_CHK != MAX_W'(MOD)) begin : g_bad_mod
    $fatal(1, "MOD is not a Solinas3 modulus");
  end
  if (!(P0 < MOD_W - 1 && P0 > P1 && P0 >= 1)) begin : g_bad_pow
    $fatal(1, "need MOD_W-1 > P0 > P1 >= 0");
  end
  if (IN_W <= MOD_W || IN_W > 2 * MOD_W) begin : g_bad_in_w
    $fatal(1, "IN_W out of range");
  end

  logic [IN_W-1:0] x0;
  logic            av0;
  logic [SW-1:0]   sd0;

  if (IN_PIPE != 0) begin : g_in_pipe
    logic [IN_W-1:0] a_q;
    always_ff @(posedge clk) a_q <= a;
    assign x0 = a_q;
    common_lib_delay_side #(
      .SIDE_W   (SW),
      .RST_SIDE (RST_SIDE)
    ) u_dly (
      .clk       (clk),
      .s_rst     (s_rst),
      .in_avail  (in_avail),
      .in_side   (in_side),
      .out_avail (av0),
      .out_side  (sd0)
    );
  end else begin : g_in_comb
    assign x0  = a;
    assign av0 = in_avail;
    assign sd0 = in_side;
  end

  // g_st[s] holds the operand entering fold s;
  // g_st[FOLD_NB] feeds the correction stage.
  for (genvar s = 0; s <= FOLD_NB; s++) begin : g_st
    localparam int W = get_fold_w(s, IN_W, MOD_W, P0);
    logic [W-1:0]  x;
    logic          av;
    logic [SW-1:0] sd;
    if (s == 0) begin : g_src
      assign x  = x0;
      assign av = av0;
      assign sd = sd0;
    end else begin : g_fold
      arith_mod_reduct_solinas3_fold #(
        .IN_W     (get_fold_w(s - 1, IN_W, MOD_W, P0)),
        .MOD_W    (MOD_W),
        .P0       (P0),
        .P1       (P1),
        .SIDE_W   (SW),
        .RST_SIDE (RST_SIDE)
      ) u_fold (
        .clk     (clk),
        .s_rst   (s_rst),
        .x_i     (g_st[s-1].x),
        .avail_i (g_st[s-1].av),
        .side_i  (g_st[s-1].sd),
        .x_o     (x),
        .avail_o (av),
        .side_o  (sd)
      );
    end
  end

  // MOD_W+1 bits is always below 3*MOD, so at most
  // two subtractions of MOD are ever needed.
  localparam logic [MOD_W:0] MOD1_E = {1'b0, MOD};
  localparam logic [MOD_W:0] MOD2_E = {MOD, 1'b0};

  logic [MOD_W:0]   v;
  logic             ge1;
  logic             ge2;
  logic [MOD_W-1:0] d1;
  logic [MOD_W-1:0] d2;
  logic [MOD_W-1:0] z_d;
  logic [MOD_W-1:0] z_q;

  assign v   = g_st[FOLD_NB].x;
  assign ge1 = (v >= MOD1_E);
  assign ge2 = (v >= MOD2_E);
  // Low-half differences are exact once the
  // true result is known to lie in [0, MOD).
  assign d1  = v[MOD_W-1:0] - MOD1_E[MOD_W-1:0];
  assign d2  = v[MOD_W-1:0] - MOD2_E[MOD_W-1:0];

  always_comb begin
    z_d = v[MOD_W-1:0];
    if (ge2)      z_d = d2;
    else if (ge1) z_d = d1;
  end

  always_ff @(posedge clk) z_q <= z_d;

  assign z = z_q;

  common_lib_delay_side #(
    .SIDE_W   (SW),
    .RST_SIDE (RST_SIDE)
  ) u_out_dly (
    .clk       (clk),
    .s_rst     (s_rst),
    .in_avail  (g_st[FOLD_NB].av),
    .in_side   (g_st[FOLD_NB].sd),
    .out_avail (out_avail),
    .out_side  (out_side)
  );

  if (LATENCY < 1) begin : g_bad_lat
    $fatal(1, "latency must be positive");
  end

endmodule

// File: tb/tb_arith_mod_reduct_solinas3.sv
// Bench for arith_mod_reduct_solinas3: big-int model
// of a % MOD delayed by the pipeline latency.
module tb_arith_mod_reduct_solinas3;

  localparam int LAT = 5;
  localparam logic [63:0]  MOD    = 64'hFFFF_FBFF_FFE0_0001;
  localparam logic [127:0] MOD128 = {64'd0, MOD};

  logic         clk = 1'b0;
  logic         s_rst;
  logic [127:0] a;
  logic         in_avail;
  logic [7:0]   in_side;
  logic [63:0]  z;
  logic         out_avail;
  logic [7:0]   out_side;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  arith_mod_reduct_solinas3 #(
    .MOD_W    (64),
    .MOD      (MOD),
    .IN_W     (128),
    .IN_PIPE  (1),
    .SIDE_W   (8),
    .RST_SIDE (2'b01)
  ) dut (
    .clk       (clk),
    .s_rst     (s_rst),
    .a         (a),
    .in_avail  (in_avail),
    .in_side   (in_side),
    .z         (z),
    .out_avail (out_avail),
    .out_side  (out_side)
  );

  task automatic chk(
    input string        nm,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  // Model: what the output must be LAT cycles
  // after each accepted operand; reset drops all.
  logic        m_av [8];
  logic [63:0] m_z  [8];
  logic [7:0]  m_sd [8];
  int unsigned ecnt     = 0;
  bit          chk_en   = 1'b0;
  bit          last_rst = 1'b0;

  initial foreach (m_av[k]) m_av[k] = 1'b0;

  always @(posedge clk) begin
    int unsigned slot;
    ecnt++;
    if (s_rst) begin
      foreach (m_av[k]) m_av[k] = 1'b0;
      chk_en = 1'b1;
    end
    last_rst = s_rst;
    slot = (ecnt + LAT - 1) % 8;
    m_av[slot] = in_avail && !s_rst;
    m_z[slot]  = 64'(a % MOD128);
    m_sd[slot] = in_side;
  end

  always @(negedge clk) begin
    int unsigned cur;
    cur = ecnt % 8;
    if (chk_en) begin
      chk("out_avail", 128'(out_avail), 128'(m_av[cur]));
      if (last_rst)
        chk("side_rst", 128'(out_side), 128'd0);
      if (m_av[cur]) begin
        chk("z", 128'(z), 128'(m_z[cur]));
        chk("out_side", 128'(out_side), 128'(m_sd[cur]));
      end
    end
  end

  logic [7:0] tag = 8'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated operand against a literal result,
  // also measuring in_avail -> out_avail latency.
  task automatic single(
    input logic [127:0] av,
    input logic [63:0]  ez,
    input string        nm
  );
    int lat;
    bit got;
    chk({nm, "_model"}, av % MOD128, 128'(ez));
    tick();
    a        = av;
    in_avail = 1'b1;
    in_side  = tag;
    tag++;
    tick();
    in_avail = 1'b0;
    a        = '0;
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (out_avail) got = 1'b1;
      else           lat++;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: no out_avail", nm);
    end else begin
      chk({nm, "_lat"}, 128'(lat), 128'(LAT));
      chk({nm, "_z"}, 128'(z), 128'(ez));
    end
  endtask

  function automatic logic [127:0] rnd_op(input int i);
    logic [127:0] r;
    logic [63:0]  k;
    r = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom};
    if (i % 97 == 0)       r = '1;
    else if (i % 89 == 0)  r = 128'(k) * MOD128;
    else if (i % 83 == 0)  r = MOD128 - 128'd1;
    return r;
  endfunction

  logic [127:0] sq;

  initial begin
    s_rst    = 1'b1;
    a        = '0;
    in_avail = 1'b0;
    in_side  = '0;
    repeat (3) tick();
    s_rst = 1'b0;
    repeat (2) tick();

    sq = 128'(MOD - 64'd1) * 128'(MOD - 64'd1);
    single(128'd0, 64'd0, "zero");
    single(128'd5, 64'd5, "five");
    single(MOD128 - 128'd1,
           64'hFFFF_FBFF_FFE0_0000, "mod_m1");
    single(MOD128, 64'd0, "mod");
    single(MOD128 + 128'd5, 64'd5, "mod_p5");
    single(MOD128 << 1, 64'd0, "mod_x2");
    single(128'd1 << 64,
           64'h0000_0400_001F_FFFF, "pow64");
    single({128{1'b1}},
           64'h4000_01FF_FFCF_FFFF, "all_ones");
    single(sq, 64'd1, "sq");

    for (int i = 0; i < 10000; i++) begin
      in_avail = ($urandom_range(0, 99) < 70);
      a        = rnd_op(i);
      if (in_avail) begin
        in_side = tag;
        tag++;
      end else begin
        in_side = 8'($urandom);
      end
      tick();
    end

    for (int i = 0; i < 4; i++) begin
      in_avail = 1'b1;
      a        = rnd_op(i + 1);
      in_side  = tag;
      tag++;
      tick();
    end
    s_rst    = 1'b1;
    a        = '1;
    in_side  = 8'hA5;
    tick();
    s_rst    = 1'b0;
    in_avail = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 6; i++) begin
      in_avail = 1'b1;
      a        = rnd_op(i + 100);
      in_side  = tag;
      tag++;
      tick();
    end
    in_avail = 1'b0;
    repeat (12) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arith_mod_reduct_solinas3.md
Name: arith_mod_reduct_solinas3

Overview:
- Pipelined modular reduction of a wide operand modulo a Solinas3 modulus MOD = 2^MOD_W - 2^P0 - 2^P1 + 1.
- Sits downstream of the Solinas3 constant multipliers and generic multipliers in the NTT/arith datapath. It turns a product of up to 2*MOD_W bits back into a canonical residue in [0, MOD).
- Streaming, fixed latency, valid-qualified (avail) with side data carried alongside.

Parameters:
- MOD_W, 64, modulus width.
- MOD, 2^64-2^42-2^21+1 (0xFFFFFBFF_FFE00001), modulus; must be Solinas3; P0, P1 derived from it.
- IN_W, 2*MOD_W, input width; must satisfy MOD_W < IN_W <= 2*MOD_W.
- IN_PIPE, 1, register the input (1) or not (0).
- SIDE_W, 0, side data width; 0 means unused.
- RST_SIDE, 0, [0]=1: reset side to 0; [1]=1: reset side to 1.

Ports:
- clk  in  1  clock.
- s_rst  in  1  reset. One clock; reset is synchronous and active-high.
- a  in  IN_W  operand.
- in_avail  in  1  operand valid.
- in_side  in  SIDE_W  side data, sampled with in_avail.
- z  out  MOD_W  a mod MOD, canonical.
- out_avail  out  1  z valid.
- out_side  out  SIDE_W  side data aligned with z.

Behaviour:
- Parameter derivation
  - P0 and P1 are recovered from MOD exactly as for the Solinas3 multiplier.
  - Elaboration $fatal if MOD != 2^MOD_W - 2^P0 - 2^P1 + 1, or if not MOD_W-1 > P0 > P1 >= 0, or if IN_W is out of range.
- Fold identity: 2^MOD_W ≡ 2^P0 + 2^P1 - 1.
  - Each fold splits x = hi*2^MOD_W + lo and computes x' = lo + (hi<<P0) + (hi<<P1) - hi.
  - x' is always non-negative because P0 >= 1.
  - The fold output width is max(MOD_W, width(hi)+P0) + 1 bits.
- Fold stages
  - FOLD_NB is the number of folds needed to bring the width down to MOD_W+1 bits or less. It is computed by a package function from IN_W, MOD_W and P0.
  - With the defaults, FOLD_NB = 3.
  - Each fold is followed by one register stage.
- Final stage: the value is below 2*MOD+small, so it is below 3*MOD.
  - Compute v-MOD and v-2*MOD in parallel.
  - Select the smallest non-negative of the three candidates.
  - Register the result.
- Latency: LATENCY = IN_PIPE + FOLD_NB + 1 cycles from in_avail to out_avail.
  - With the defaults, LATENCY = 5.
  - Full throughput: one operand per cycle, no back-pressure.
  - in_avail gaps propagate unchanged.
- Control path
  - avail and side travel through a common_lib_delay_side chain with the same per-stage latency.
  - Data registers are not reset.
  - While s_rst=1, every avail register is cleared on each clock, so out_avail=0 from the first clock edge with s_rst=1.
  - Side registers follow RST_SIDE.
  - out_avail and out_side are registered outputs and hold their reset values until reset is released.
- Reset mid-stream: all in-flight operands are dropped and no spurious out_avail occurs afterwards. The first valid output appears LATENCY cycles after the first post-reset in_avail.
- z is don't-care when out_avail=0. The bench checks z only when out_avail=1.
- Boundaries
  - a = MOD gives z = 0.
  - a = k*MOD gives z = 0.
  - An a whose top bits are all 1 must not overflow any fold stage; stage widths are sized by the package function, not hard-coded.

Decomposition:
- Package arith_mod_reduct_solinas3_pkg contains:
  - get_int_pow(MOD, MOD_W), returning P0 and P1;
  - get_fold_nb(IN_W, MOD_W, P0);
  - get_fold_w(stage, ...), giving the per-stage width;
  - get_latency(IN_PIPE, FOLD_NB).
- One sub-module, arith_mod_reduct_solinas3_fold. It is parameterised by IN_W, MOD_W, P0 and P1, performs one registered fold, and carries its own delay_side for avail and side.
- The top level instantiates FOLD_NB fold sub-modules in a generate loop, followed by the correction stage.

Test Plan:
- Small values: a=0 → z=0; a=5 → z=5; a=MOD-1 → z=0xFFFFFBFF_FFE00000. out_avail rises exactly 5 cycles after in_avail.
- Modulus multiples: a=MOD → 0; a=MOD+5 → 5; a=2*MOD → 0.
- Power of two: a=2^64 → z=0x00000400_001FFFFF (2^42+2^21-1). a=2^128-1 → z matches the reference model (big-int a % MOD).
- Square of MOD-1: a=(MOD-1)^2 → z=1.
- Stream with side data: 10k random 128-bit operands with random in_avail gaps, SIDE_W=8, side = sequence tag. Check:
  - every z equals a % MOD;
  - out_side tags arrive in order and unchanged;
  - the out_avail pattern equals the in_avail pattern delayed by 5 cycles.
- Reset mid-stream: assert s_rst for 1 cycle while 4 operands are in flight. Check:
  - out_avail=0 starting from that clock edge and until 5 cycles after the next in_avail;
  - with RST_SIDE=1, out_side=0 during reset;
  - the operands that follow are reduced correctly.
